// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable multi-channel even-ratio clock divider.
// Optional build macro CLKDIV_PHASE_ALIGN_EN enables the sync phase-align strobe.
`default_nettype none

module clock_divider_prog #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 24,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] pend
);

  logic align;

`ifdef CLKDIV_PHASE_ALIGN_EN
  assign align = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign align       = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             hit;
    logic             tc;
    logic [CNT_W-1:0] next_half;

    // Equality against the channel index also rejects out-of-range selects.
    assign hit       = wr_en && (wr_ch == CH_W'(i));
    assign tc        = en[i] && (cnt_q == half_q);
    assign next_half = hit ? wr_data : (pend_q ? pval_q : half_q);

    always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      pval_d = pval_q;
      pend_d = pend_q;
      clk_d  = clk_q;
      rise_d = 1'b0;
      if (align) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        half_d = next_half;
        pend_d = 1'b0;
      end else if (tc) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        rise_d = ~clk_q;
        half_d = next_half;
        pend_d = 1'b0;
      end else begin
        if (en[i]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (hit) begin
          pend_d = 1'b1;
          pval_d = wr_data;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q  <= '0;
        half_q <= CNT_W'(DEFAULT_HALF);
        pval_q <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        half_q <= half_d;
        pval_q <= pval_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        rise_q <= rise_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign rise[i]    = rise_q;
    assign pend[i]    = pend_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: randomized self-checking bench against a countdown reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_clock_divider_prog;

  localparam int NCH = 3;
  localparam int CW  = 5;
  localparam int DH  = 24;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_data;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] pend;

  clock_divider_prog #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_HALF(DH),
    .CH_W        (CHW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_data(wr_data),
    .sync   (sync),
    .clk_out(clk_out),
    .rise   (rise),
    .pend   (pend)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: each half-period is a countdown of remaining enabled cycles.
  int m_lvl  [NCH];
  int m_rem  [NCH];
  int m_half [NCH];
  int m_pv   [NCH];
  int m_ph   [NCH];
  int m_rise [NCH];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lvl[c]  = 0;
      m_rem[c]  = DH;
      m_half[c] = DH;
      m_pv[c]   = 0;
      m_ph[c]   = 0;
      m_rise[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      int nh;
      bit do_align;
      hit = wr_en && (int'(wr_ch) == c);
      nh  = hit ? int'(wr_data) : (m_ph[c] != 0 ? m_pv[c] : m_half[c]);
      do_align = 1'b0;
`ifdef CLKDIV_PHASE_ALIGN_EN
      do_align = sync;
`endif
      if (do_align) begin
        m_half[c] = nh;
        m_rem[c]  = nh;
        m_lvl[c]  = 0;
        m_rise[c] = 0;
        m_ph[c]   = 0;
      end else if (en[c] && m_rem[c] == 0) begin
        m_half[c] = nh;
        m_rem[c]  = nh;
        m_lvl[c]  = 1 - m_lvl[c];
        m_rise[c] = m_lvl[c];
        m_ph[c]   = 0;
      end else begin
        if (en[c]) m_rem[c] = m_rem[c] - 1;
        m_rise[c] = 0;
        if (hit) begin
          m_ph[c] = 1;
          m_pv[c] = int'(wr_data);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ec, er, ep;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = (m_lvl[c] != 0);
      er[c] = (m_rise[c] != 0);
      ep[c] = (m_ph[c] != 0);
    end
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("rise",    32'(rise),    32'(er));
    chk("pend",    32'(pend),    32'(ep));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rand_inputs(input bit allow_big);
    int r;
    for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 7) != 0);
    wr_en = ($urandom_range(0, 3) == 0);
    wr_ch = CHW'($urandom_range(0, 3));
    r = $urandom_range(0, 9);
    if (r < 5)                    wr_data = CW'($urandom_range(0, 3));
    else if (r < 9 || !allow_big) wr_data = CW'($urandom_range(4, 10));
    else                          wr_data = CW'(31);
    sync = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    reset   = 1'b0;
    en      = '0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    sync    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_rise",    32'(rise),    32'd0);
    chk("rst_pend",    32'(pend),    32'd0);
    reset = 1'b1;

    // Directed opening: defaults, mid-phase write, coincident write, en freeze, bad channel.
    for (int cyc = 0; cyc < 140; cyc++) begin
      en    = '1;
      wr_en = 1'b0;
      sync  = 1'b0;
      if (cyc == 10) begin wr_en = 1'b1; wr_ch = 2'd1; wr_data = 5'd4; end
      if (cyc >= 28 && cyc < 35) en[0] = 1'b0;
      if (cyc == 40) begin wr_en = 1'b1; wr_ch = 2'd3; wr_data = 5'd1; end
      if (cyc == 49) begin wr_en = 1'b1; wr_ch = 2'd2; wr_data = 5'd0; end
      if (cyc == 60) sync = 1'b1;
      if (cyc == 70) begin wr_en = 1'b1; wr_ch = 2'd0; wr_data = 5'd2; end
      if (cyc == 72) begin wr_en = 1'b1; wr_ch = 2'd0; wr_data = 5'd6; end
      if (cyc == 100) begin wr_en = 1'b1; wr_ch = 2'd1; wr_data = 5'd31; end
      cycle();
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_inputs(1'b1);
      cycle();
    end

    // Asynchronous reset mid-cycle, then confirm restart from default ratio.
    reset = 1'b0;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'd0);
    chk("arst_rise",    32'(rise),    32'd0);
    chk("arst_pend",    32'(pend),    32'd0);
    model_reset();
    #2;
    reset = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      en    = '1;
      wr_en = 1'b0;
      sync  = 1'b0;
      cycle();
    end

    for (int cyc = 0; cyc < 1000; cyc++) begin
      rand_inputs(1'b0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_divider_prog.md
# clock_divider_prog

Parametrised, runtime-programmable multi-channel clock divider for the vehicle control fabric. Each of NUM_CH channels divides the system clock by an even ratio 2*(half+1), set per channel through a write port. Outputs are a square enable-level `clk_out` plus a one-cycle `rise` strobe per channel. Ratio changes are applied only at a half-period boundary so no output glitches or truncated phases occur. It serves motor PWM, sensor-sampling and timer domains.

## Interface
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 16, counter/half-period register width in bits
- DEFAULT_HALF, 24, reset value of every channel's half-period register (50 MHz -> 1 MHz)
- CH_W, $clog2(NUM_CH) (min 1), width of channel select
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  NUM_CH  per-channel run enable
- wr_en  input  1  write strobe for half-period register
- wr_ch  input  CH_W  target channel of write
- wr_data  input  CNT_W  new half-period value
- sync  input  1  phase-align strobe (active only with CLKDIV_PHASE_ALIGN_EN)
- clk_out  output  NUM_CH  divided square output per channel
- rise  output  NUM_CH  one-cycle pulse when clk_out goes 0->1
- pend  output  NUM_CH  write accepted, not yet applied

## Operation
- Per channel state: cnt[CNT_W], half_r[CNT_W], pend_val[CNT_W], pend flag, clk_out, rise.
- Reset (reset=0, async): cnt=0, half_r=DEFAULT_HALF, pend_val=0, pend=0, clk_out=0, rise=0, all channels.
- Terminal count: tc = en[ch] && (cnt == half_r).
- en=1, !tc: cnt <= cnt+1; clk_out holds.
- tc: cnt <= 0; clk_out toggles; half_r updated per write rules below.
- en=0: cnt, clk_out, half_r hold; pend may still be set; rise=0.
- rise[ch] = 1 in exactly the cycle clk_out[ch] first reads 1 (registered together); 0 otherwise.
- Write: wr_en && wr_ch < NUM_CH; out-of-range wr_ch ignored, no state change.
  - Not coincident with tc: pend_val <= wr_data, pend <= 1. Later write before apply overwrites (last wins).
  - At tc: half_r <= (write to this ch this cycle) ? wr_data : (pend ? pend_val : half_r); pend <= 0.
- half=0 legal: clk_out toggles every enabled cycle (divide by 2). half=2^CNT_W-1 legal, no overflow (cnt never exceeds half_r).
- Counter compare is equality only; since updates occur only at cnt=0 boundary, cnt>half_r is unreachable.

## Timing
- Period per channel = 2*(half_r+1) clk cycles; duty exactly 50%.
- First clk_out rise after reset with en held high: at edge half_r+1 (cycle DEFAULT_HALF+1 = 25 for defaults).
- Write latency: new ratio governs the half-period starting after the next tc; write coincident with tc governs the immediately following half-period.
- pend visible the cycle after write; cleared the cycle after the applying tc.
- en deassert mid-count freezes phase; reassert resumes from frozen cnt, no extra cycle.
- Reset mid-operation: all outputs 0 immediately (async), restart from DEFAULT_HALF on release.

## Configuration
- CLKDIV_PHASE_ALIGN_EN defined: sync=1 on a clock edge forces every channel cnt<=0, clk_out<=0, rise<=0; pending writes are applied to half_r in that cycle, pend<=0; sync overrides tc and en. Channels with equal ratios are phase-aligned afterwards.
- Not defined: sync port present but ignored; no alignment logic synthesised.

## Test plan
- Reset release, defaults, en=4'b1111 -> each clk_out rises at cycle 25, period 50 cycles, rise pulses 1 cycle every 50.
- Write ch1 half=4 mid-half-period -> pend[1]=1 until next tc, then period 10 cycles, no short phase; other channels unchanged.
- Write ch2 half=0 in same cycle as its tc -> pend[2] never set, ch2 toggles every cycle immediately; two writes before tc on ch3 -> last value applied.
- en[0] low for 7 cycles mid-count -> clk_out[0] and cnt frozen, total half-period stretched by exactly 7; wr_ch=NUM_CH ignored.
- Assert reset low mid-operation -> all outputs 0 same cycle, half_r back to 24.
- With CLKDIV_PHASE_ALIGN_EN: ch0/ch1 half=9 out of phase, pulse sync -> both clk_out 0, then rise together 10 cycles later; without macro sync has no effect.
